// File: rtl/l1_arbiter.sv
// l1_arbiter: shares one downstream line port between the L1 I-cache and
// the L1 D-cache, one full-line transaction at a time.
//
// Handshake on every port: a requester raises read/write together with its
// address (and write data) and holds them all steady until the cycle its
// resp is 1. resp is a single-cycle pulse, and rdata is meaningful only in
// that cycle. There is no separate ready: resp is both the completion and
// the acceptance. Downstream follows the same rule, with this block as the
// requester.
module l1_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128,
   parameter int FAIR   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_pmem_read,
   input  logic [ADDR_W-1:0] i_pmem_address,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_address,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      GAP     = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;
   // 1 when the most recently completed transaction belonged to the D-cache
   logic   last_grant_d;
   logic   last_grant_d_nxt;
   logic   req_i;
   logic   req_d;

   // State register and round-robin memory; reset aborts any in-flight line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant_d <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_grant_d <= last_grant_d_nxt;
      end
   end

   // Grant selection plus combinational pass-through of the granted client
   always_comb begin
      state_nxt        = state;
      last_grant_d_nxt = last_grant_d;
      req_i            = i_pmem_read;
      req_d            = d_pmem_read | d_pmem_write;
      l2_read          = 1'b0;
      l2_write         = 1'b0;
      l2_address       = '0;
      l2_wdata         = '0;
      i_pmem_resp      = 1'b0;
      i_pmem_rdata     = '0;
      d_pmem_resp      = 1'b0;
      d_pmem_rdata     = '0;
      case (state)
         IDLE: begin
            // l2_resp is deliberately ignored here: nothing is outstanding
            if (req_i && req_d) begin
               if ((FAIR != 0) && last_grant_d) state_nxt = SERVE_I;
               else                             state_nxt = SERVE_D;
            end else if (req_d) begin
               state_nxt = SERVE_D;
            end else if (req_i) begin
               state_nxt = SERVE_I;
            end
         end
         SERVE_I: begin
            l2_read    = i_pmem_read;
            l2_address = i_pmem_address;
            if (l2_resp) begin
               i_pmem_resp      = 1'b1;
               i_pmem_rdata     = l2_rdata;
               state_nxt        = GAP;
               last_grant_d_nxt = 1'b0;
            end
         end
         SERVE_D: begin
            l2_address = d_pmem_address;
            l2_wdata   = d_pmem_wdata;
            // a write-back takes precedence if the client raises both
            if (d_pmem_write) l2_write = 1'b1;
            else              l2_read  = d_pmem_read;
            if (l2_resp) begin
               d_pmem_resp      = 1'b1;
               d_pmem_rdata     = l2_rdata;
               state_nxt        = GAP;
               last_grant_d_nxt = 1'b1;
            end
         end
         GAP: begin
            // one dead cycle so the finished client can drop its stale request
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_l1_arbiter.sv
// tb_l1_arbiter: directed scenarios plus randomized client traffic, with
// every output compared each cycle against a transaction-level model.
// Two arbiters share the stimulus: one round-robin and one with D priority.
// Only the selected one is out of reset at any time.
module tb_l1_arbiter;
   localparam int AW = 16;
   localparam int LW = 128;
   localparam int NONE = 0;
   localparam int CL_I = 1;
   localparam int CL_D = 2;

   logic          clk;
   logic          rst_n_fair;
   logic          rst_n_prio;
   logic          i_pmem_read;
   logic [AW-1:0] i_pmem_address;
   logic          d_pmem_read;
   logic          d_pmem_write;
   logic [AW-1:0] d_pmem_address;
   logic [LW-1:0] d_pmem_wdata;
   logic [LW-1:0] l2_rdata;
   logic          l2_resp;

   logic [LW-1:0] f_i_rdata, f_d_rdata, f_l2_wdata;
   logic          f_i_resp, f_d_resp, f_l2_read, f_l2_write;
   logic [AW-1:0] f_l2_address;
   logic [LW-1:0] p_i_rdata, p_d_rdata, p_l2_wdata;
   logic          p_i_resp, p_d_resp, p_l2_read, p_l2_write;
   logic [AW-1:0] p_l2_address;

   // outputs of whichever arbiter is currently under test
   logic [LW-1:0] o_i_rdata, o_d_rdata, o_l2_wdata;
   logic          o_i_resp, o_d_resp, o_l2_read, o_l2_write;
   logic [AW-1:0] o_l2_address;
   bit            fair_sel;

   int checks = 0;
   int errors = 0;

   // reference model: who owns the downstream port, pending dead cycle,
   // and whether D finished last
   int m_owner;
   bit m_gap;
   bit m_last_d;

   l1_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FAIR(1)) dut_fair (
      .clk(clk), .rst_n(rst_n_fair),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(f_i_rdata), .i_pmem_resp(f_i_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(f_d_rdata), .d_pmem_resp(f_d_resp),
      .l2_read(f_l2_read), .l2_write(f_l2_write), .l2_address(f_l2_address),
      .l2_wdata(f_l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
   );

   l1_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FAIR(0)) dut_prio (
      .clk(clk), .rst_n(rst_n_prio),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(p_i_rdata), .i_pmem_resp(p_i_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(p_d_rdata), .d_pmem_resp(p_d_resp),
      .l2_read(p_l2_read), .l2_write(p_l2_write), .l2_address(p_l2_address),
      .l2_wdata(p_l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
   );

   always_comb begin
      o_i_rdata    = fair_sel ? f_i_rdata    : p_i_rdata;
      o_d_rdata    = fair_sel ? f_d_rdata    : p_d_rdata;
      o_l2_wdata   = fair_sel ? f_l2_wdata   : p_l2_wdata;
      o_i_resp     = fair_sel ? f_i_resp     : p_i_resp;
      o_d_resp     = fair_sel ? f_d_resp     : p_d_resp;
      o_l2_read    = fair_sel ? f_l2_read    : p_l2_read;
      o_l2_write   = fair_sel ? f_l2_write   : p_l2_write;
      o_l2_address = fair_sel ? f_l2_address : p_l2_address;
   end

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // expected outputs follow from who owns the port right now
   task automatic compare_outputs();
      logic          e_read, e_write, e_iresp, e_dresp;
      logic [AW-1:0] e_addr;
      logic [LW-1:0] e_wdata, e_irdata, e_drdata;
      e_read = 1'b0; e_write = 1'b0; e_iresp = 1'b0; e_dresp = 1'b0;
      e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
      if (m_owner == CL_I) begin
         e_read = i_pmem_read;
         e_addr = i_pmem_address;
         if (l2_resp) begin
            e_iresp  = 1'b1;
            e_irdata = l2_rdata;
         end
      end else if (m_owner == CL_D) begin
         e_addr  = d_pmem_address;
         e_wdata = d_pmem_wdata;
         e_write = d_pmem_write;
         e_read  = d_pmem_read & ~d_pmem_write;
         if (l2_resp) begin
            e_dresp  = 1'b1;
            e_drdata = l2_rdata;
         end
      end
      assert (!((m_owner == CL_I && !i_pmem_read) ||
                (m_owner == CL_D && !(d_pmem_read || d_pmem_write))))
      else begin
         errors++;
         $error("FAIL req_drop owner=%0d withdrew its request mid-transaction", m_owner);
      end
      check("l2_read",    LW'(o_l2_read),    LW'(e_read));
      check("l2_write",   LW'(o_l2_write),   LW'(e_write));
      check("l2_address", LW'(o_l2_address), LW'(e_addr));
      check("l2_wdata",   o_l2_wdata,        e_wdata);
      check("i_resp",     LW'(o_i_resp),     LW'(e_iresp));
      check("i_rdata",    o_i_rdata,         e_irdata);
      check("d_resp",     LW'(o_d_resp),     LW'(e_dresp));
      check("d_rdata",    o_d_rdata,         e_drdata);
   endtask

   // one clock: check at negedge, advance the model across the posedge
   task automatic step_cycle();
      int   n_owner;
      bit   n_gap;
      bit   n_last;
      logic cur_rst;
      logic want_i;
      logic want_d;
      @(negedge clk);
      compare_outputs();
      n_owner = m_owner;
      n_gap   = m_gap;
      n_last  = m_last_d;
      cur_rst = fair_sel ? rst_n_fair : rst_n_prio;
      want_i  = i_pmem_read;
      want_d  = d_pmem_read | d_pmem_write;
      if (!cur_rst) begin
         n_owner = NONE; n_gap = 1'b0; n_last = 1'b0;
      end else if (m_owner != NONE) begin
         if (l2_resp) begin
            n_last  = (m_owner == CL_D);
            n_owner = NONE;
            n_gap   = 1'b1;
         end
      end else if (m_gap) begin
         n_gap = 1'b0;
      end else if (want_i && want_d) begin
         n_owner = (fair_sel && m_last_d) ? CL_I : CL_D;
      end else if (want_d) begin
         n_owner = CL_D;
      end else if (want_i) begin
         n_owner = CL_I;
      end
      @(posedge clk);
      m_owner  = n_owner;
      m_gap    = n_gap;
      m_last_d = n_last;
      #1;
   endtask

   task automatic clear_inputs();
      i_pmem_read = 1'b0; i_pmem_address = '0;
      d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
      l2_rdata = '0; l2_resp = 1'b0;
   endtask

   task automatic hard_reset(input bit fair);
      rst_n_fair = 1'b0;
      rst_n_prio = 1'b0;
      fair_sel   = fair;
      clear_inputs();
      m_owner = NONE; m_gap = 1'b0; m_last_d = 1'b0;
      #1;
      compare_outputs();
      step_cycle();
      if (fair) rst_n_fair = 1'b1;
      else      rst_n_prio = 1'b1;
   endtask

   // randomized clients that obey the hold-until-resp rule
   task automatic rand_step();
      int op;
      l2_resp  = ($urandom_range(0, 2) == 0);
      l2_rdata = rand_line();
      if (i_pmem_read) begin
         if (m_owner != CL_I &&
             ((m_gap && !m_last_d && $urandom_range(0, 3) != 0) || $urandom_range(0, 7) == 0))
            i_pmem_read = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
         i_pmem_read    = 1'b1;
         i_pmem_address = AW'($urandom());
      end
      if (d_pmem_read || d_pmem_write) begin
         if (m_owner != CL_D &&
             ((m_gap && m_last_d && $urandom_range(0, 3) != 0) || $urandom_range(0, 7) == 0)) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         op             = $urandom_range(0, 3);
         d_pmem_read    = (op != 2);
         d_pmem_write   = (op >= 2);
         d_pmem_address = AW'($urandom());
         d_pmem_wdata   = rand_line();
      end
      step_cycle();
   endtask

   // stimulus
   initial begin
      logic [LW-1:0] wb_line;
      logic [LW-1:0] a5_line;
      wb_line = 128'h0123456789ABCDEF0123456789ABCDEF;
      a5_line = {16{8'hA5}};

      // I-cache read, resp three cycles after the grant
      hard_reset(1'b1);
      i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
      step_cycle();
      check("t1_l2_read", LW'(o_l2_read), LW'(1'b1));
      check("t1_l2_address", LW'(o_l2_address), LW'(16'h1230));
      step_cycle();
      step_cycle();
      l2_resp = 1'b1; l2_rdata = a5_line;
      #1;
      check("t1_i_resp", LW'(o_i_resp), LW'(1'b1));
      check("t1_i_rdata", o_i_rdata, a5_line);
      check("t1_d_resp", LW'(o_d_resp), LW'(1'b0));
      step_cycle();
      l2_resp = 1'b0; i_pmem_read = 1'b0;
      #1;
      check("t1_i_resp_pulse", LW'(o_i_resp), LW'(1'b0));
      step_cycle();

      // D-cache write-back, request held through the dead cycle
      d_pmem_write = 1'b1; d_pmem_address = 16'h4440; d_pmem_wdata = wb_line;
      step_cycle();
      check("t2_l2_write", LW'(o_l2_write), LW'(1'b1));
      check("t2_l2_read", LW'(o_l2_read), LW'(1'b0));
      check("t2_l2_wdata", o_l2_wdata, wb_line);
      step_cycle();
      l2_resp = 1'b1; l2_rdata = rand_line();
      #1;
      check("t2_d_resp", LW'(o_d_resp), LW'(1'b1));
      check("t2_i_resp", LW'(o_i_resp), LW'(1'b0));
      step_cycle();
      l2_resp = 1'b0;
      #1;
      check("t2_gap_l2_write", LW'(o_l2_write), LW'(1'b0));
      step_cycle();
      d_pmem_write = 1'b0;
      step_cycle();

      // stray l2_resp while idle, then an immediate grant
      l2_resp = 1'b1; l2_rdata = rand_line();
      #1;
      check("t3_idle_i_resp", LW'(o_i_resp), LW'(1'b0));
      check("t3_idle_d_resp", LW'(o_d_resp), LW'(1'b0));
      step_cycle();
      l2_resp = 1'b0; i_pmem_read = 1'b1; i_pmem_address = 16'h0ABC;
      step_cycle();
      check("t3_grant_after_idle", LW'(o_l2_read), LW'(1'b1));
      l2_resp = 1'b1;
      step_cycle();
      l2_resp = 1'b0; i_pmem_read = 1'b0;
      step_cycle();

      // D raises read and write together: the write goes downstream
      d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h7770;
      d_pmem_wdata = rand_line();
      step_cycle();
      check("t4_l2_write", LW'(o_l2_write), LW'(1'b1));
      check("t4_l2_read", LW'(o_l2_read), LW'(1'b0));
      l2_resp = 1'b1;
      step_cycle();
      l2_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      step_cycle();

      // reset pulse one cycle before l2_resp in SERVE_I
      i_pmem_read = 1'b1; i_pmem_address = 16'h3210;
      step_cycle();
      step_cycle();
      rst_n_fair = 1'b0;
      m_owner = NONE; m_gap = 1'b0; m_last_d = 1'b0;
      #1;
      check("t5_rst_l2_read", LW'(o_l2_read), LW'(1'b0));
      check("t5_rst_l2_address", LW'(o_l2_address), LW'(16'h0));
      step_cycle();
      rst_n_fair = 1'b1; l2_resp = 1'b1; l2_rdata = rand_line();
      #1;
      check("t5_late_resp_i", LW'(o_i_resp), LW'(1'b0));
      step_cycle();
      l2_resp = 1'b0;
      #1;
      check("t5_fresh_grant", LW'(o_l2_read), LW'(1'b1));
      check("t5_fresh_address", LW'(o_l2_address), LW'(16'h3210));
      step_cycle();
      l2_resp = 1'b1;
      step_cycle();
      l2_resp = 1'b0; i_pmem_read = 1'b0;
      step_cycle();

      // round-robin with both clients requesting continuously
      hard_reset(1'b1);
      i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
      d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
      for (int k = 0; k < 4; k++) begin
         step_cycle();
         check("rr_grant_address", LW'(o_l2_address), (k % 2 == 0) ? LW'(16'h2000) : LW'(16'h0100));
         step_cycle();
         l2_resp = 1'b1; l2_rdata = rand_line();
         step_cycle();
         l2_resp = 1'b0;
         step_cycle();
      end
      clear_inputs();
      step_cycle();
      repeat (500) rand_step();

      // D priority: D keeps winning until it lets go
      hard_reset(1'b0);
      i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
      d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
      for (int k = 0; k < 3; k++) begin
         step_cycle();
         check("prio_grant_d", LW'(o_l2_address), LW'(16'h2000));
         step_cycle();
         l2_resp = 1'b1; l2_rdata = rand_line();
         step_cycle();
         l2_resp = 1'b0;
         if (k == 2) d_pmem_read = 1'b0;
         step_cycle();
      end
      step_cycle();
      check("prio_grant_i_after_drop", LW'(o_l2_address), LW'(16'h0100));
      l2_resp = 1'b1;
      step_cycle();
      clear_inputs();
      step_cycle();
      repeat (500) rand_step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/l1_arbiter.md
Name: l1_arbiter

Overview:
- Arbitrates the physical-memory ports of the L1 instruction cache and L1 data cache onto one downstream line port (L2 cache or physical memory).
- Serves one full-line transaction at a time: 128-bit read or write, 16-bit line address.
- Fairness is round-robin or fixed data-cache priority.
- The upstream port protocol matches what the L1 cache controller already drives: request held until a one-cycle resp, rdata valid with resp.

Parameters:
- ADDR_W, 16, address width (lc3b_word)
- LINE_W, 128, line width (lc3b_mem_data)
- FAIR, 1, 1 = round-robin between I and D; 0 = D always wins a tie

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_pmem_read  input  1  I-cache line read request
- i_pmem_address  input  ADDR_W  I-cache line address
- i_pmem_rdata  output  LINE_W  line data to I-cache
- i_pmem_resp  output  1  I-cache transaction complete
- d_pmem_read  input  1  D-cache line read request
- d_pmem_write  input  1  D-cache line write-back request
- d_pmem_address  input  ADDR_W  D-cache line address
- d_pmem_wdata  input  LINE_W  D-cache write-back data
- d_pmem_rdata  output  LINE_W  line data to D-cache
- d_pmem_resp  output  1  D-cache transaction complete
- l2_read  output  1  downstream read request
- l2_write  output  1  downstream write request
- l2_address  output  ADDR_W  downstream address
- l2_wdata  output  LINE_W  downstream write data
- l2_rdata  input  LINE_W  downstream read data
- l2_resp  input  1  downstream transaction complete

Behaviour:
- Reset: the asynchronous assert of rst_n=0 has the following effects:
  - state goes to IDLE and last_grant goes to I.
  - All outputs go to 0: l2_read, l2_write, l2_address, l2_wdata, both resps and both rdatas.
- States and transitions:
  - IDLE: downstream outputs are 0 and l2_resp is ignored.
    - req_i = i_pmem_read.
    - req_d = d_pmem_read | d_pmem_write.
    - If only one request is present, go to the matching SERVE_I or SERVE_D.
    - If both are present: with FAIR=1, grant the one not in last_grant; with FAIR=0, go to SERVE_D.
  - SERVE_I: l2_read=i_pmem_read, l2_address=i_pmem_address, l2_write=0, l2_wdata=0.
  - SERVE_D: l2_address=d_pmem_address, l2_wdata=d_pmem_wdata.
    - If d_pmem_write=1: l2_write=1 and l2_read=0. Write wins if the client asserts both.
    - Otherwise: l2_read=d_pmem_read.
  - SERVE_x on l2_resp=1:
    - In the same cycle, drive x_pmem_resp=1 and x_pmem_rdata=l2_rdata combinationally.
    - Next state is GAP; last_grant <= x.
  - GAP: exactly 1 cycle with all downstream requests 0, then IDLE. This lets the completed client drop its stale request so it is not re-granted.
- Latency:
  - A request first seen in IDLE at edge N puts l2 request outputs high from N+1.
  - Client resp is zero-cycle relative to l2_resp.
  - Minimum spacing between back-to-back grants is 2 cycles after resp (GAP, then IDLE).
- Non-granted client: its resp=0 and rdata=0 at all times. i_pmem_resp and d_pmem_resp are never both 1.
- Request withdrawal:
  - A client dropping its request mid-transaction is illegal. The arbiter stays in SERVE_x until l2_resp.
  - The bench must flag a drop as an assertion failure.
- l2_resp in IDLE or GAP: ignored, with no resp forwarded.
- Mid-transaction reset: the arbiter aborts to IDLE immediately and does not remember the in-flight transaction.
- Outputs in SERVE states are a combinational pass-through of the granted client. The state register and last_grant are the only flops.
- FAIR=1 ensures no starvation: with both requesting continuously, grants alternate D, I, D, I...

Test Plan:
- Reset, then I reads 0x1230 with l2_resp 3 cycles later and l2_rdata=128'hA5..A5:
  - l2_read=1 with l2_address=0x1230 from the cycle after the request.
  - i_pmem_resp=1 for 1 cycle with i_pmem_rdata=A5..A5.
  - d_pmem_resp stays 0.
- D write-back to 0x4440 with wdata=128'h0123..CDEF:
  - l2_write=1, l2_read=0, and l2_wdata matches.
  - d_pmem_resp is pulsed on l2_resp.
  - Then GAP, then IDLE, with l2_write=0 in GAP.
- Simultaneous I read 0x0100 and D read 0x2000 held continuously, FAIR=1, out of reset:
  - D is served first, then I after GAP, then D again.
  - Each l2_address matches the granted client.
- Same simultaneous stimulus with FAIR=0:
  - D is served until it drops its request; I is granted only after.
- rst_n pulled low for 1 cycle in SERVE_I, 1 cycle before l2_resp:
  - All outputs are 0 immediately.
  - A later l2_resp produces no i_pmem_resp.
  - After rst_n rises with I still requesting, a fresh grant starts.
- l2_resp asserted while IDLE with no requests:
  - No resp is forwarded and the state stays IDLE.
- D asserts read and write together:
  - l2_write=1 and l2_read=0.
